keypad_debounce: RTL and testbench



---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_debounce_if.sv | 33 +++
 rtl/debounce_counter.sv | 41 ++++
 rtl/keypad_debounce.sv | 171 +++++++++++++++++
 tb/tb_keypad_debounce.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key code width, debounce FSM encoding and counter sizing.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [1:0]       state_t;

  localparam state_t IDLE        = 2'd0;
  localparam state_t DEB_PRESS   = 2'd1;
  localparam state_t PRESSED     = 2'd2;
  localparam state_t DEB_RELEASE = 2'd3;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_debounce_if.sv
// Scanner-side raw key inputs and the conditioned key outputs of the debounce stage.
interface keypad_debounce_if;
  import keypad_pkg::*;

  key_t raw_key;
  logic raw_valid;
  key_t key;
  logic key_valid;
  logic key_pulse;
  logic key_repeat;
  logic release_pulse;

  modport slave (
    input  raw_key,
    input  raw_valid,
    output key,
    output key_valid,
    output key_pulse,
    output key_repeat,
    output release_pulse
  );

  modport master (
    output raw_key,
    output raw_valid,
    input  key,
    input  key_valid,
    input  key_pulse,
    input  key_repeat,
    input  release_pulse
  );

endinterface

// File: rtl/debounce_counter.sv
// Up-counter with clear, load-to-1 and enable; flags when the next increment reaches terminal.
module debounce_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_one,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             at_terminal
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH:0]   cnt_inc;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load_one) begin
      cnt_d = WIDTH'(1);
    end else if (enable && !(&cnt_q)) begin
      // Saturate rather than wrap.
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_inc     = {1'b0, cnt_q} + (WIDTH + 1)'(1);
  assign at_terminal = (cnt_inc == {1'b0, terminal});

endmodule

// File: rtl/keypad_debounce.sv
// Debounces the scanner's key code into a held key, press/release strobes and auto-repeat.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_RATE     = 0
) (
  input  logic               clk,
  input  logic               reset,
  keypad_debounce_if.slave   bus
);

  localparam int unsigned DEB_W     = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned REP_W     = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
  localparam bit          REPEAT_EN = (REPEAT_DELAY > 0);

  state_t state_q, state_d;
  key_t   cand_q, cand_d;
  key_t   key_q, key_d;
  logic   key_valid_q, key_valid_d;
  logic   key_pulse_q, key_pulse_d;
  logic   key_repeat_q, key_repeat_d;
  logic   release_pulse_q, release_pulse_d;
  logic   rep_first_q, rep_first_d;

  logic   deb_clear, deb_load, deb_inc, deb_hit;
  logic   rep_clear, rep_inc, rep_hit;
  logic   deviate;

  logic [REP_W-1:0] rep_term;

  // First repeat waits REPEAT_DELAY after the press; later ones are REPEAT_RATE apart.
  assign rep_term = rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
  assign deviate  = !bus.raw_valid || (bus.raw_key != key_q);

  debounce_counter #(
    .WIDTH (DEB_W)
  ) u_deb_cnt (
    .clk         (clk),
    .reset       (reset),
    .clear       (deb_clear),
    .load_one    (deb_load),
    .enable      (deb_inc),
    .terminal    (DEB_W'(DEBOUNCE_CYCLES)),
    .at_terminal (deb_hit)
  );

  debounce_counter #(
    .WIDTH (REP_W)
  ) u_rep_cnt (
    .clk         (clk),
    .reset       (reset),
    .clear       (rep_clear),
    .load_one    (1'b0),
    .enable      (rep_inc),
    .terminal    (rep_term),
    .at_terminal (rep_hit)
  );

  always_comb begin
    state_d         = state_q;
    cand_d          = cand_q;
    key_d           = key_q;
    key_valid_d     = key_valid_q;
    key_pulse_d     = 1'b0;
    key_repeat_d    = 1'b0;
    release_pulse_d = 1'b0;
    rep_first_d     = rep_first_q;
    deb_clear       = 1'b0;
    deb_load        = 1'b0;
    deb_inc         = 1'b0;
    rep_clear       = 1'b0;
    rep_inc         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.raw_valid) begin
          cand_d   = bus.raw_key;
          deb_load = 1'b1;
          state_d  = DEB_PRESS;
        end
      end

      DEB_PRESS: begin
        if (!bus.raw_valid) begin
          deb_clear = 1'b1;
          state_d   = IDLE;
        end else if (bus.raw_key != cand_q) begin
          // Code changed mid-debounce: restart the run on the new code.
          cand_d   = bus.raw_key;
          deb_load = 1'b1;
        end else if (deb_hit) begin
          state_d     = PRESSED;
          key_d       = cand_q;
          key_valid_d = 1'b1;
          key_pulse_d = 1'b1;
          deb_clear   = 1'b1;
          rep_clear   = 1'b1;
          rep_first_d = 1'b1;
        end else begin
          deb_inc = 1'b1;
        end
      end

      PRESSED: begin
        if (deviate) begin
          deb_load = 1'b1;
          state_d  = DEB_RELEASE;
        end else if (REPEAT_EN) begin
          if (rep_hit) begin
            key_pulse_d  = 1'b1;
            key_repeat_d = 1'b1;
            rep_clear    = 1'b1;
            rep_first_d  = 1'b0;
          end else begin
            rep_inc = 1'b1;
          end
        end
      end

      DEB_RELEASE: begin
        if (!deviate) begin
          // Glitch: resume the held key; the repeat count is left untouched.
          deb_clear = 1'b1;
          state_d   = PRESSED;
        end else if (deb_hit) begin
          key_valid_d     = 1'b0;
          release_pulse_d = 1'b1;
          deb_clear       = 1'b1;
          state_d         = IDLE;
        end else begin
          deb_inc = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cand_q          <= '0;
      key_q           <= '0;
      key_valid_q     <= 1'b0;
      key_pulse_q     <= 1'b0;
      key_repeat_q    <= 1'b0;
      release_pulse_q <= 1'b0;
      rep_first_q     <= 1'b1;
    end else begin
      state_q         <= state_d;
      cand_q          <= cand_d;
      key_q           <= key_d;
      key_valid_q     <= key_valid_d;
      key_pulse_q     <= key_pulse_d;
      key_repeat_q    <= key_repeat_d;
      release_pulse_q <= release_pulse_d;
      rep_first_q     <= rep_first_d;
    end
  end

  assign bus.key           = key_q;
  assign bus.key_valid     = key_valid_q;
  assign bus.key_pulse     = key_pulse_q;
  assign bus.key_repeat    = key_repeat_q;
  assign bus.release_pulse = release_pulse_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with a run-length behavioural model checked every cycle.
module tb_keypad_debounce;

  localparam int DEB   = 4;
  localparam int DELAY = 20;
  localparam int RATE  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  keypad_debounce_if bus ();

  keypad_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_RATE     (RATE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model: run length of identical valid samples while up, count of deviating samples
  // while down, and hold time (cycles of steady key since the press).
  bit       m_down = 1'b0;
  bit [3:0] m_key = '0;
  bit       m_pulse = 1'b0, m_rep = 1'b0, m_rel = 1'b0;
  bit [3:0] run_key = '0;
  int       run_len = 0;
  int       dev = 0;
  int       held = 0;

  always @(posedge clk) begin
    m_pulse = 1'b0;
    m_rep   = 1'b0;
    m_rel   = 1'b0;
    if (reset) begin
      m_down  = 1'b0;
      m_key   = '0;
      run_len = 0;
      run_key = '0;
      dev     = 0;
      held    = 0;
    end else if (!m_down) begin
      if (!bus.raw_valid) begin
        run_len = 0;
      end else if (run_len > 0 && bus.raw_key == run_key) begin
        run_len++;
      end else begin
        run_key = bus.raw_key;
        run_len = 1;
      end
      if (run_len == DEB) begin
        m_down  = 1'b1;
        m_key   = run_key;
        m_pulse = 1'b1;
        run_len = 0;
        held    = 0;
        dev     = 0;
      end
    end else begin
      if (!bus.raw_valid || bus.raw_key != m_key) begin
        dev++;
        if (dev == DEB) begin
          m_down  = 1'b0;
          m_rel   = 1'b1;
          dev     = 0;
          run_len = 0;
        end
      end else if (dev > 0) begin
        dev = 0;
      end else begin
        held++;
        if (held >= DELAY && ((held - DELAY) % RATE) == 0) begin
          m_pulse = 1'b1;
          m_rep   = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      n_cmp++;
      if ({bus.key, bus.key_valid, bus.key_pulse, bus.key_repeat, bus.release_pulse} !==
          {m_key, m_down, m_pulse, m_rep, m_rel}) begin
        n_err++;
        $display("FAIL model t=%0t dut key=%h v=%b p=%b r=%b rel=%b want key=%h v=%b p=%b r=%b rel=%b",
                 $time, bus.key, bus.key_valid, bus.key_pulse, bus.key_repeat, bus.release_pulse,
                 m_key, m_down, m_pulse, m_rep, m_rel);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Present one sample, let the DUT take it, return at the following negedge.
  task automatic apply(input logic rst, input logic v, input logic [3:0] k);
    reset         = rst;
    bus.raw_valid = v;
    bus.raw_key   = k;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] outs();
    return {bus.key, bus.key_valid, bus.key_pulse, bus.key_repeat, bus.release_pulse};
  endfunction

  int pulses;
  int rel_idx;
  int press_idx;

  initial begin
    bus.raw_valid = 1'b1;
    bus.raw_key   = 4'd5;

    // Reset held with a valid key present.
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, 4'd5);
      check_en = 1'b1;
      check("reset_outs", 32'(outs()), 32'd0);
    end

    // Press of 5 accepted on the 4th identical sample.
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 4'd5);
      check("press_pulse", 32'(bus.key_pulse), (i == 3) ? 32'd1 : 32'd0);
    end
    check("press_key", 32'(bus.key), 32'd5);
    check("press_valid", 32'(bus.key_valid), 32'd1);
    check("press_norep", 32'(bus.key_repeat), 32'd0);
    apply(1'b0, 1'b1, 4'd5);
    check("press_once", 32'(bus.key_pulse), 32'd0);

    // Bounce: 2 valid, 1 invalid, 4 valid.
    apply(1'b1, 1'b0, 4'd0);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, i != 2, 4'd5);
      pulses += int'(bus.key_pulse);
    end
    check("bounce_last", 32'(bus.key_pulse), 32'd1);
    check("bounce_count", 32'(pulses), 32'd1);
    check("bounce_key", 32'(bus.key), 32'd5);

    // Code change mid-debounce: 5,5,9,9,9,9.
    apply(1'b1, 1'b0, 4'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b1, (i < 2) ? 4'd5 : 4'd9);
      pulses += int'(bus.key_pulse);
    end
    check("change_last", 32'(bus.key_pulse), 32'd1);
    check("change_count", 32'(pulses), 32'd1);
    check("change_key", 32'(bus.key), 32'd9);

    // Hold A: repeats at press+20, +28, +36.
    apply(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 4'hA);
    check("hold_press", 32'(bus.key_pulse), 32'd1);
    for (int j = 1; j <= 40; j++) begin
      apply(1'b0, 1'b1, 4'hA);
      check("repeat_pulse", {bus.key_pulse, bus.key_repeat, bus.key_valid},
            (j == 20 || j == 28 || j == 36) ? 32'd7 : 32'd1);
    end

    // Release with glitch: 0,0,A,0,0,0,0.
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, i == 2, 4'hA);
      pulses += int'(bus.release_pulse);
      check("glitch_nokey", 32'(bus.key_pulse), 32'd0);
    end
    check("release_pulse", 32'(bus.release_pulse), 32'd1);
    check("release_count", 32'(pulses), 32'd1);
    check("release_valid", 32'(bus.key_valid), 32'd0);
    check("release_key", 32'(bus.key), 32'hA);

    // Different key while held: release after 4 samples of 7, new press after 4 more.
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 4'd3);
    rel_idx = 0;
    press_idx = 0;
    for (int i = 1; i <= 10; i++) begin
      apply(1'b0, 1'b1, 4'd7);
      if (bus.release_pulse) rel_idx = i;
      if (bus.key_pulse) press_idx = i;
    end
    check("swap_release_at", 32'(rel_idx), 32'd4);
    check("swap_press_at", 32'(press_idx), 32'd8);
    check("swap_key", 32'(bus.key), 32'd7);

    // Reset while in DEB_PRESS discards the pending press.
    apply(1'b1, 1'b0, 4'd0);
    apply(1'b0, 1'b1, 4'd3);
    apply(1'b0, 1'b1, 4'd3);
    apply(1'b1, 1'b1, 4'd3);
    check("midreset_outs", 32'(outs()), 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 4'd3);
      pulses += int'(bus.key_pulse);
    end
    check("midreset_nopulse", 32'(pulses), 32'd0);

    // Deterministic mixed traffic, checked by the model only.
    for (int i = 0; i < 300; i++) begin
      apply(1'b0, (i % 11) != 0 && (i % 53) < 45, 4'((i / 37) % 3 + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
